ntps_axil_mux: RTL and testbench

Parametrised AXI4-Lite single-master to N-slave switch. It sits between the PCIe-AXI bridge master port and the register slaves in the ntps interfaces layer: NTP clocks, MDIO control and pvtmon. It replaces fixed per-index bus slicing with address decoding, and adds three behaviours:
- DECERR responses for unmapped slave indices.
- SLVERR responses when a slave hangs past a timeout.
- A saturating timeout event counter for diagnostics.

It has one outstanding transaction at a time, and all outputs are registered.

---
 rtl/ntps_axil_mux_if.sv | 28 ++
 rtl/ntps_axil_mux.sv | 185 ++++++++++++++++++
 tb/tb_ntps_axil_mux.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntps_axil_mux_if.sv
// ntps_axil_mux_if: N-slot AXI4-Lite bundle; N=1 is a plain single-port bus.
interface ntps_axil_mux_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32
);
    logic [N*ADDR_W-1:0] awaddr;
    logic [N*ADDR_W-1:0] araddr;
    logic [N*3-1:0]      awprot;
    logic [N*3-1:0]      arprot;
    logic [N*32-1:0]     wdata;
    logic [N*32-1:0]     rdata;
    logic [N*4-1:0]      wstrb;
    logic [N*2-1:0]      bresp;
    logic [N*2-1:0]      rresp;
    logic [N-1:0]        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [N-1:0]        arvalid, arready, rvalid, rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ntps_axil_mux.sv
// ntps_axil_mux: AXI4-Lite one-master to N-slave switch with address decode,
// DECERR for unmapped slots and SLVERR aborts on hung slaves.
module ntps_axil_mux #(
    parameter int NUM_SLAVES     = 12,
    parameter int ADDR_W         = 32,
    parameter int SEL_LSB        = 16,
    parameter int SEL_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            axi_aclk,
    input  logic            axi_aresetn,
    ntps_axil_mux_if.slave  s_axi,
    ntps_axil_mux_if.master m_axi,
    output logic            timeout_pulse,
    output logic [15:0]     timeout_count
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, W_REQ, W_RSP, B_OUT, R_REQ, R_RSP, R_OUT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2:0]            prot_q, prot_d;
    logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            resp_q, resp_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
    logic                  awready_q, awready_d, arready_q, arready_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [NUM_SLAVES-1:0] awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [NUM_SLAVES-1:0] bready_q, bready_d, rready_q, rready_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pulse_q, pulse_d;
    logic [15:0]           tcount_q, tcount_d;
    logic [NUM_SLAVES-1:0] oh;
    logic                  busy, launch, wr_req;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        prot_d    = prot_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        sel_d     = sel_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        tcount_d  = tcount_q;
        awready_d = 1'b0;
        arready_d = 1'b0;
        pulse_d   = 1'b0;
        busy      = state_q inside {W_REQ, W_RSP, R_REQ, R_RSP};
        cnt_d     = busy ? cnt_q + 1'b1 : cnt_q;
        wr_req    = s_axi.awvalid[0] && s_axi.wvalid[0];
        // A response handshake doubles as an idle cycle so the next accept follows at once
        launch    = (state_q == IDLE && !awready_q && !arready_q)
                 || (state_q == B_OUT && s_axi.bready[0])
                 || (state_q == R_OUT && s_axi.rready[0]);
        if (launch) begin
            state_d   = IDLE;
            awready_d = wr_req;
            arready_d = !wr_req && s_axi.arvalid[0];
        end else if (awready_q) begin
            addr_d    = s_axi.awaddr;
            prot_d    = s_axi.awprot;
            wdata_d   = s_axi.wdata;
            wstrb_d   = s_axi.wstrb;
            sel_d     = s_axi.awaddr[SEL_LSB +: SEL_W];
            cnt_d     = '0;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            resp_d    = 2'b11;
            state_d   = (int'(sel_d) >= NUM_SLAVES) ? B_OUT : W_REQ;
        end else if (arready_q) begin
            addr_d  = s_axi.araddr;
            prot_d  = s_axi.arprot;
            sel_d   = s_axi.araddr[SEL_LSB +: SEL_W];
            cnt_d   = '0;
            rdata_d = '0;
            resp_d  = 2'b11;
            state_d = (int'(sel_d) >= NUM_SLAVES) ? R_OUT : R_REQ;
        end else if (state_q == W_REQ) begin
            aw_pend_d = aw_pend_q && !m_axi.awready[sel_q];
            w_pend_d  = w_pend_q && !m_axi.wready[sel_q];
            state_d   = (!aw_pend_d && !w_pend_d) ? W_RSP : W_REQ;
        end else if (state_q == W_RSP && m_axi.bvalid[sel_q]) begin
            resp_d  = m_axi.bresp[{sel_q, 1'b0} +: 2];
            state_d = B_OUT;
        end else if (state_q == R_REQ && m_axi.arready[sel_q]) begin
            state_d = R_RSP;
        end else if (state_q == R_RSP && m_axi.rvalid[sel_q]) begin
            rdata_d = m_axi.rdata[{sel_q, 5'd0} +: 32];
            resp_d  = m_axi.rresp[{sel_q, 1'b0} +: 2];
            state_d = R_OUT;
        end
        if (busy && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = (state_q == W_REQ || state_q == W_RSP) ? B_OUT : R_OUT;
            rdata_d  = (state_d == R_OUT) ? 32'd0 : rdata_d;
            resp_d   = 2'b10;
            pulse_d  = 1'b1;
            tcount_d = (tcount_q == 16'hFFFF) ? tcount_q : tcount_q + 16'd1;
        end
        oh        = NUM_SLAVES'(1) << sel_d;
        awvalid_d = (state_d == W_REQ && aw_pend_d) ? oh : '0;
        wvalid_d  = (state_d == W_REQ && w_pend_d) ? oh : '0;
        bready_d  = (state_d == W_RSP) ? oh : '0;
        arvalid_d = (state_d == R_REQ) ? oh : '0;
        rready_d  = (state_d == R_RSP) ? oh : '0;
        bvalid_d  = state_d == B_OUT;
        rvalid_d  = state_d == R_OUT;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            prot_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            sel_q     <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            awvalid_q <= '0;
            wvalid_q  <= '0;
            arvalid_q <= '0;
            bready_q  <= '0;
            rready_q  <= '0;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
            tcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            prot_q    <= prot_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            sel_q     <= sel_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            tcount_q  <= tcount_d;
        end
    end

    assign s_axi.awready  = awready_q;
    assign s_axi.wready   = awready_q;
    assign s_axi.arready  = arready_q;
    assign s_axi.bvalid   = bvalid_q;
    assign s_axi.rvalid   = rvalid_q;
    assign s_axi.bresp    = resp_q;
    assign s_axi.rresp    = resp_q;
    assign s_axi.rdata    = rdata_q;
    assign m_axi.awaddr   = {NUM_SLAVES{addr_q}};
    assign m_axi.araddr   = {NUM_SLAVES{addr_q}};
    assign m_axi.awprot   = {NUM_SLAVES{prot_q}};
    assign m_axi.arprot   = {NUM_SLAVES{prot_q}};
    assign m_axi.wdata    = {NUM_SLAVES{wdata_q}};
    assign m_axi.wstrb    = {NUM_SLAVES{wstrb_q}};
    assign m_axi.awvalid  = awvalid_q;
    assign m_axi.wvalid   = wvalid_q;
    assign m_axi.arvalid  = arvalid_q;
    assign m_axi.bready   = bready_q;
    assign m_axi.rready   = rready_q;
    assign timeout_pulse  = pulse_q;
    assign timeout_count  = tcount_q;
endmodule

// File: tb/tb_ntps_axil_mux.sv
// tb_ntps_axil_mux: randomized and directed checks of the AXI4-Lite switch
// against a transaction-level latency/response model and slave register files.
module tb_ntps_axil_mux;
    localparam int NS = 12;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic        timeout_pulse;
    logic [15:0] timeout_count;
    int          n_chk = 0, n_err = 0, cyc = 0, viol = 0, pulses = 0;
    logic [NS-1:0] allow = '0;
    bit          force_b2 = 1'b0;
    int          da [NS], dw [NS], db [NS];
    bit          hang [NS];
    logic [1:0]  rsp [NS];
    logic [31:0] smem [NS][16];
    logic [31:0] ref_mem [NS][16];
    int          ref_tc = 0;

    ntps_axil_mux_if #(.N(1), .ADDR_W(32)) s ();
    ntps_axil_mux_if #(.N(NS), .ADDR_W(32)) m ();

    ntps_axil_mux #(.NUM_SLAVES(NS), .ADDR_W(32), .SEL_LSB(16), .SEL_W(4), .TIMEOUT_CYCLES(TO)) dut (
        .axi_aclk(clk), .axi_aresetn(axi_aresetn), .s_axi(s), .m_axi(m),
        .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (((m.awvalid | m.wvalid | m.bready | m.arvalid | m.rready) & ~allow) != '0) viol <= viol + 1;
        if (timeout_pulse) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave models: each slot holds a register file and answers after its configured delays
    initial begin
        int awc [NS], wc [NS], bc [NS], arc [NS], rc [NS];
        int w;
        m.awready = '0; m.wready = '0; m.bvalid = '0; m.bresp = '0;
        m.arready = '0; m.rvalid = '0; m.rresp = '0; m.rdata = '0;
        for (int i = 0; i < NS; i++) begin
            awc[i] = 0; wc[i] = 0; bc[i] = 0; arc[i] = 0; rc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                m.awready[i] = m.awvalid[i] && awc[i] >= da[i];
                awc[i] = m.awvalid[i] ? awc[i] + 1 : 0;
                m.wready[i] = m.wvalid[i] && wc[i] >= dw[i];
                wc[i] = m.wvalid[i] ? wc[i] + 1 : 0;
                m.arready[i] = m.arvalid[i] && arc[i] >= da[i];
                arc[i] = m.arvalid[i] ? arc[i] + 1 : 0;
                m.bresp[2*i +: 2] = rsp[i];
                m.rresp[2*i +: 2] = rsp[i];
                if (m.bready[i] && !hang[i] && bc[i] >= db[i]) begin
                    m.bvalid[i] = 1'b1;
                    w = int'(m.awaddr[32*i+2 +: 4]);
                    for (int b = 0; b < 4; b++)
                        if (m.wstrb[4*i+b]) smem[i][w][8*b +: 8] = m.wdata[32*i+8*b +: 8];
                end else begin
                    m.bvalid[i] = force_b2 && i == 2;
                end
                bc[i] = m.bready[i] ? bc[i] + 1 : 0;
                if (m.rready[i] && !hang[i] && rc[i] >= db[i]) begin
                    m.rvalid[i] = 1'b1;
                    m.rdata[32*i +: 32] = smem[i][int'(m.araddr[32*i+2 +: 4])];
                end else begin
                    m.rvalid[i] = 1'b0;
                end
                rc[i] = m.rready[i] ? rc[i] + 1 : 0;
            end
        end
    end

    function automatic int exp_lat(input int sel, input bit is_wr);
        if (sel >= NS) return 1;
        if (hang[sel]) return TO + 1;
        return 3 + (is_wr ? (da[sel] > dw[sel] ? da[sel] : dw[sel]) : da[sel]) + db[sel];
    endfunction

    function automatic logic [1:0] exp_resp(input int sel);
        if (sel >= NS) return 2'b11;
        if (hang[sel]) return 2'b10;
        return rsp[sel];
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                      output logic [1:0] resp, output int lat);
        int n, t0;
        @(negedge clk);
        s.awaddr = a; s.awprot = 3'b010; s.wdata = d; s.wstrb = st;
        s.awvalid = 1'b1; s.wvalid = 1'b1; s.bready = 1'b1;
        n = 0;
        while (!s.awready[0] && n < 50) begin @(negedge clk); n++; end
        check("wr_accept", s.awready, 1);
        t0 = cyc;
        @(negedge clk);
        s.awvalid = 1'b0; s.wvalid = 1'b0;
        n = 0;
        while (!s.bvalid[0] && n < 100) begin @(negedge clk); n++; end
        lat = cyc - t0;
        resp = s.bresp;
        @(negedge clk);
        s.bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
        int n, t0;
        @(negedge clk);
        s.araddr = a; s.arprot = 3'b001; s.arvalid = 1'b1; s.rready = 1'b1;
        n = 0;
        while (!s.arready[0] && n < 50) begin @(negedge clk); n++; end
        check("rd_accept", s.arready, 1);
        t0 = cyc;
        @(negedge clk);
        s.arvalid = 1'b0;
        n = 0;
        while (!s.rvalid[0] && n < 100) begin @(negedge clk); n++; end
        lat = cyc - t0;
        resp = s.rresp;
        d = s.rdata;
        @(negedge clk);
        s.rready = 1'b0;
    endtask

    task automatic ref_write(input int sel, input int w, input logic [31:0] d, input logic [3:0] st);
        if (sel < NS && !hang[sel])
            for (int b = 0; b < 4; b++) if (st[b]) ref_mem[sel][w][8*b +: 8] = d[8*b +: 8];
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d, a, wd;
        logic [3:0]  st;
        int          lat, v0, p0, sel, w, n, c;
        bit          is_wr;
        s.awaddr = '0; s.awprot = '0; s.wdata = '0; s.wstrb = '0; s.awvalid = 1'b0; s.wvalid = 1'b0;
        s.bready = 1'b0; s.araddr = '0; s.arprot = '0; s.arvalid = 1'b0; s.rready = 1'b0;
        for (int i = 0; i < NS; i++) begin
            da[i] = 0; dw[i] = 0; db[i] = 0; hang[i] = 1'b0; rsp[i] = 2'b00;
            for (int j = 0; j < 16; j++) begin smem[i][j] = '0; ref_mem[i][j] = '0; end
        end
        repeat (3) @(negedge clk);
        check("rst_awready", s.awready, 0);
        check("rst_bvalid", s.bvalid, 0);
        check("rst_rvalid", s.rvalid, 0);
        check("rst_m_valids", m.awvalid | m.wvalid | m.arvalid | m.bready | m.rready, 0);
        check("rst_tcount", timeout_count, 0);
        axi_aresetn = 1'b1;

        // Zero-wait write to slave 1
        allow = NS'(1) << 1;
        v0 = viol;
        wr(32'h0001_0004, 32'h1234_5678, 4'hF, resp, lat);
        ref_write(1, 1, 32'h1234_5678, 4'hF);
        check("w1_lat", lat, 3);
        check("w1_resp", resp, 0);
        check("w1_slot", viol - v0, 0);

        // Slave 7 read with 5 wait cycles
        smem[7][0] = 32'hCAFE_F00D; ref_mem[7][0] = 32'hCAFE_F00D; db[7] = 5;
        allow = NS'(1) << 7;
        v0 = viol;
        rd(32'h0007_0000, d, resp, lat);
        check("r7_data", d, 32'hCAFE_F00D);
        check("r7_resp", resp, 0);
        check("r7_lat", lat, 8);
        check("r7_slot", viol - v0, 0);
        db[7] = 0;

        // Unmapped slot 12
        allow = '0;
        v0 = viol;
        rd(32'h000C_0000, d, resp, lat);
        check("dec_data", d, 0);
        check("dec_resp", resp, 2'b11);
        check("dec_lat", lat, 1);
        check("dec_slot", viol - v0, 0);

        // Slave 2 hangs on B: timeout, then a late bvalid is ignored
        hang[2] = 1'b1;
        allow = NS'(1) << 2;
        p0 = pulses;
        wr(32'h0002_0000, 32'hDEAD_BEEF, 4'hF, resp, lat);
        ref_tc++;
        check("to_resp", resp, 2'b10);
        check("to_lat", lat, TO + 1);
        check("to_pulses", pulses - p0, 1);
        check("to_count", timeout_count, ref_tc);
        force_b2 = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (m.bready[2] || s.bvalid[0]) n++;
        end
        check("late_b_ignored", n, 0);
        force_b2 = 1'b0; hang[2] = 1'b0;
        @(negedge clk);

        // Simultaneous write and read to slave 4: write first, read right after B handshake
        allow = NS'(1) << 4;
        s.awaddr = 32'h0004_0008; s.wdata = 32'hA5A5_0F0F; s.wstrb = 4'hF; s.araddr = 32'h0004_0008;
        s.awvalid = 1'b1; s.wvalid = 1'b1; s.arvalid = 1'b1; s.bready = 1'b1; s.rready = 1'b0;
        ref_write(4, 2, 32'hA5A5_0F0F, 4'hF);
        n = 0;
        while (!s.awready[0] && n < 50) begin @(negedge clk); n++; end
        check("sim_ar_held", s.arready, 0);
        @(negedge clk);
        s.awvalid = 1'b0; s.wvalid = 1'b0;
        n = 0;
        while (!s.bvalid[0] && n < 50) begin @(negedge clk); n++; end
        check("sim_bresp", s.bresp, rsp[4]);
        @(negedge clk);
        s.bready = 1'b0;
        check("sim_ar_next", s.arready, 1);
        s.rready = 1'b1;
        @(negedge clk);
        s.arvalid = 1'b0;
        n = 0;
        while (!s.rvalid[0] && n < 50) begin @(negedge clk); n++; end
        check("sim_rdata", s.rdata, ref_mem[4][2]);
        @(negedge clk);
        s.rready = 1'b0;

        // Reset asserted while W_REQ is waiting on slave 3
        da[3] = 10;
        allow = NS'(1) << 3;
        @(negedge clk);
        s.awaddr = 32'h0003_0000; s.wdata = 32'h1111_2222; s.wstrb = 4'hF;
        s.awvalid = 1'b1; s.wvalid = 1'b1; s.bready = 1'b1;
        n = 0;
        while (!m.awvalid[3] && n < 10) begin
            @(negedge clk);
            n++;
            if (s.awready[0]) begin s.awvalid = 1'b0; s.wvalid = 1'b0; end
        end
        check("rst_pre_awvalid", m.awvalid[3], 1);
        s.awvalid = 1'b0; s.wvalid = 1'b0; s.bready = 1'b0;
        #2 axi_aresetn = 1'b0;
        #1 check("rst_async_awvalid", m.awvalid, 0);
        check("rst_async_tcount", timeout_count, 0);
        ref_tc = 0;
        @(negedge clk);
        axi_aresetn = 1'b1;
        da[3] = 0;
        wr(32'h0003_0004, 32'h3333_4444, 4'h3, resp, lat);
        ref_write(3, 1, 32'h3333_4444, 4'h3);
        check("post_rst_lat", lat, 3);
        check("post_rst_resp", resp, 0);
        rd(32'h0003_0004, d, resp, lat);
        check("post_rst_rdata", d, ref_mem[3][1]);

        // Randomized mix against the transaction-level model
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 15);
            w = $urandom_range(0, 15);
            is_wr = $urandom_range(0, 1) == 1;
            if (sel < NS) begin
                da[sel] = $urandom_range(0, 4); dw[sel] = $urandom_range(0, 4);
                db[sel] = $urandom_range(0, 4); hang[sel] = $urandom_range(0, 7) == 0;
                rsp[sel] = $urandom_range(0, 3) == 0 ? 2'b10 : 2'b00;
                allow = NS'(1) << sel;
            end else begin
                allow = '0;
            end
            a = {12'h000, 4'(sel), 10'h000, 4'(w), 2'b00};
            v0 = viol; p0 = pulses;
            c = (sel < NS && hang[sel]) ? 1 : 0;
            ref_tc += c;
            if (is_wr) begin
                wd = $urandom; st = 4'($urandom_range(0, 15));
                wr(a, wd, st, resp, lat);
                ref_write(sel, w, wd, st);
                check("rnd_w_resp", resp, exp_resp(sel));
                check("rnd_w_lat", lat, exp_lat(sel, 1'b1));
            end else begin
                rd(a, d, resp, lat);
                check("rnd_r_resp", resp, exp_resp(sel));
                check("rnd_r_lat", lat, exp_lat(sel, 1'b0));
                check("rnd_r_data", d, (sel >= NS || hang[sel]) ? 32'd0 : ref_mem[sel][w]);
            end
            check("rnd_slot", viol - v0, 0);
            check("rnd_pulses", pulses - p0, c);
            check("rnd_tcount", timeout_count, ref_tc);
            if (sel < NS) hang[sel] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
